skew_feeder: RTL and testbench
==============================

// Module: skew_feeder
// PURPOSE
//  Parametrised successor to the activation skew stage in front of the systolic array.
//  Accepts one N-row column per valid/ready beat and delays row i by i cycles.
//  Emits rows with per-row valid/last tags and masks rows at or above active_rows.
//  Enforces tile boundaries: no new tile is accepted until the previous one has drained.
// PARAMETERS
//  N           4   array rows (>=1)
//  DATA_W      8   bits per element
// PORTS
//  clk          in   1         clock
//  reset        in   1         asynchronous, active-high; clears all state
//  array_en     in   1         global advance; 0 freezes the whole pipeline
//  in_valid     in   1         column beat valid
//  in_ready     out  1         column beat accepted when in_valid&in_ready
//  in_data      in   N*DATA_W  row i = in_data[i*DATA_W +: DATA_W]
//  in_last      in   1         beat is the last column of the tile
//  active_rows  in   RW        rows in use (1..N); sampled on first beat of a tile
//  out_data     out  N*DATA_W  skewed row data, same slicing as in_data
//  out_valid    out  N         per-row element valid
//  out_last     out  N         per-row last-column tag
//  tile_done    out  1         1-cycle pulse with out_last[K-1] (K = latched active_rows)
//  busy         out  1         state != IDLE
// BEHAVIOUR
//  Reset: out_data=0, out_valid=0, out_last=0, tile_done=0, busy=0, state=IDLE, K=N.
//  advance = array_en. When advance=0, every register (FSM included) holds.
//  When advance=1, every stage shifts. Cycles without a fire inject a bubble (data 0, valid 0, last 0).
//  Latency: a column fired in cycle c shows row i at the outputs in cycle c+1+i.
//  Masking: rows i>=K carry data 0 and valid 0 for the whole tile. RW = $clog2(N+1).
//  active_rows of 0 or >N is clamped to N.
//  FSM:
//   IDLE   in_ready=array_en; fire latches K; ->STREAM, or ->DRAIN if in_last
//   STREAM in_ready=array_en; fire with in_last -> DRAIN
//   DRAIN  in_ready=0; on advance with out_last[K-1] -> IDLE; tile_done=1 that cycle
//  in_ready depends only on state and array_en, never on in_valid.
//  A single-beat tile (in_last on its first beat) is legal. For K=1, DRAIN lasts 1 cycle.
//  Back-to-back tiles: the first beat of the next tile is accepted in the cycle after tile_done.
//  If array_en drops in the same cycle out_last[K-1] appears, outputs and tile_done hold until advance.
//  tile_done is asserted for exactly one advancing cycle.
//  Reset mid-tile: all in-flight data is discarded; state returns to IDLE asynchronously.
// CONFIGURATION
//  SKEW_FEEDER_DESKEW_EN defined:
//   adds input port deskew (1 bit), sampled with active_rows on the first beat of a tile.
//   deskew=1: row i is delayed K-1-i stages, for re-aligning array outputs.
//   DRAIN then exits on out_last[0].
//  Macro undefined: the port does not exist and forward skew is always used.
// STRUCTURE
//  Package skew_pkg: state enum typedef {IDLE,STREAM,DRAIN}; function clamp_rows().
//  Sub-module skew_delay_line #(DEPTH, DATA_W): DEPTH-stage shift of {data,valid,last}
//   with an enable input; DEPTH=0 is a wire.
//  One instance per row, followed by that row's output register.
//  In deskew mode, a per-row tap select chooses the delay depth.
// TESTING (N=4, DATA_W=8)
//  1 Reset, then a tile of 4 columns 0x11..0x44 per row (row i = col+i), K=4
//    -> row i valid in cycles c+1+i..c+4+i; tile_done coincides with out_last[3]; no gaps.
//  2 active_rows=2, 3-column tile
//    -> out_valid[3:2] stay 0 with data 0; tile_done coincides with out_last[1]; DRAIN lasts 2 cycles.
//  3 array_en low for 3 cycles mid-STREAM and during DRAIN
//    -> all outputs frozen; in_ready=0; after release the sequence resumes with no loss or duplication.
//  4 Single-beat tile followed immediately by a second tile
//    -> in_ready=0 until the cycle after tile_done; tile 2 K is sampled independently.
//  5 Async reset asserted mid-STREAM between clock edges
//    -> outputs 0 and busy 0 immediately; the next tile behaves as in test 1.
//  6 (DESKEW_EN) deskew=1, K=4
//    -> row 3 undelayed, row 0 delayed 3 stages; tile_done coincides with out_last[0].

Source files
------------

// File: rtl/skew_pkg.sv
// Shared types and helpers for the skew feeder: FSM state encoding,
// active-row clamping and tap-select width sizing.
package skew_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    // Rows in use: 0 or anything above the array height means "all rows".
    function automatic int clamp_rows(input int rows, input int n);
        int res;
        if ((rows == 0) || (rows > n)) begin
            res = n;
        end else begin
            res = rows;
        end
        return res;
    endfunction

    // Bits needed to select one of depth+1 taps (at least one bit).
    function automatic int sel_width(input int depth);
        int res;
        if (depth > 0) begin
            res = $clog2(depth + 1);
        end else begin
            res = 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// DEPTH-stage shift register of {data, valid, last} with a global enable.
// Tap 0 is the input itself, tap k is the value k advances ago; i_sel picks
// the tap presented at the output. i_clr flushes stages 1..DEPTH-1 while
// stage 0 still loads the input, so leftovers of a finished tile cannot
// surface through a deeper tap later. DEPTH=0 degenerates to a wire.
module skew_delay_line
    import skew_pkg::*;
#(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 8,
    localparam int SELW  = sel_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic [SELW-1:0]   i_sel,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    input  logic              i_last,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_last
);

    logic [DEPTH:0][DATA_W-1:0] w_tap_data;
    logic [DEPTH:0]             w_tap_valid;
    logic [DEPTH:0]             w_tap_last;

    generate
        if (DEPTH > 0) begin : g_stages
            logic [DEPTH-1:0][DATA_W-1:0] r_data;
            logic [DEPTH-1:0]             r_valid;
            logic [DEPTH-1:0]             r_last;

            // Shift one stage per advance; optional flush of the older stages.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_data  <= '0;
                    r_valid <= '0;
                    r_last  <= '0;
                end else if (i_en) begin
                    r_data[0]  <= i_data;
                    r_valid[0] <= i_valid;
                    r_last[0]  <= i_last;
                    for (int k = 1; k < DEPTH; k++) begin
                        r_data[k]  <= i_clr ? {DATA_W{1'b0}} : r_data[k-1];
                        r_valid[k] <= i_clr ? 1'b0 : r_valid[k-1];
                        r_last[k]  <= i_clr ? 1'b0 : r_last[k-1];
                    end
                end
            end

            assign w_tap_data  = {r_data, i_data};
            assign w_tap_valid = {r_valid, i_valid};
            assign w_tap_last  = {r_last, i_last};
        end else begin : g_wire
            assign w_tap_data  = i_data;
            assign w_tap_valid = i_valid;
            assign w_tap_last  = i_last;
        end
    endgenerate

    assign o_data  = w_tap_data[i_sel];
    assign o_valid = w_tap_valid[i_sel];
    assign o_last  = w_tap_last[i_sel];

endmodule

// File: rtl/skew_feeder.sv
// Activation skew stage in front of the systolic array. One N-row column is
// accepted per valid/ready beat; row i reaches the outputs i advances later.
// Rows at or above the tile's active row count are zero for the whole tile,
// and a new tile is only accepted once the previous one has fully drained.
// Optional feature macro SKEW_FEEDER_DESKEW_EN adds a deskew input that
// reverses the skew (row i delayed K-1-i) to re-align array outputs.
module skew_feeder
    import skew_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    localparam int RW    = $clog2(N + 1),
    localparam int SW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              array_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic [RW-1:0]     active_rows,
`ifdef SKEW_FEEDER_DESKEW_EN
    input  logic              deskew,
`endif
    output logic [N*DATA_W-1:0] out_data,
    output logic [N-1:0]      out_valid,
    output logic [N-1:0]      out_last,
    output logic              tile_done,
    output logic              busy
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [RW-1:0] r_k;
    logic [RW-1:0] w_k_in;
    logic [RW-1:0] w_k;
    logic [SW-1:0] w_exit;
    logic          w_in_ready;
    logic          w_fire;
    logic          w_first;
    logic          w_done;
    logic          w_clr;

    assign w_k_in  = RW'(clamp_rows(int'(active_rows), N));
    // The first beat of a tile already needs K before it is latched.
    assign w_k     = (r_state == IDLE) ? w_k_in : r_k;
    assign w_fire  = in_valid & w_in_ready;
    assign w_first = w_fire & (r_state == IDLE);
    // Once the tile ends the delay lines hold only stale taps; flush them.
    assign w_clr   = w_done & array_en;

`ifdef SKEW_FEEDER_DESKEW_EN
    logic r_dsk;
    logic w_dsk;

    assign w_dsk  = (r_state == IDLE) ? deskew : r_dsk;
    // Deskewed tiles finish on row 0, which carries the longest delay.
    assign w_exit = r_dsk ? {SW{1'b0}} : SW'(r_k - RW'(1'b1));

    // Tile mode latched together with K on the first beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dsk <= 1'b0;
        end else if (w_first) begin
            r_dsk <= deskew;
        end
    end
`else
    assign w_exit = SW'(r_k - RW'(1'b1));
`endif

    // Active row count for the current tile; defaults to all rows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_k <= RW'(N);
        end else if (w_first) begin
            r_k <= w_k_in;
        end
    end

    // FSM state register; frozen whenever the array is not advancing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else if (array_en) begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, ready and tile completion; ready never looks at in_valid.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = array_en;
                if (in_valid && array_en) begin
                    w_state_nxt = in_last ? DRAIN : STREAM;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            STREAM: begin
                w_in_ready = array_en;
                if (in_valid && array_en && in_last) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_state_nxt = STREAM;
                end
            end
            DRAIN: begin
                w_done = out_last[w_exit];
                if (array_en && w_done) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DRAIN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign in_ready  = w_in_ready;
    assign tile_done = w_done;
    assign busy      = (r_state != IDLE);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_row
`ifdef SKEW_FEEDER_DESKEW_EN
            localparam int D = N - 1;
`else
            localparam int D = gi;
`endif
            localparam int SELW_R = sel_width(D);

            logic              w_row_on;
            logic [DATA_W-1:0] w_inj_data;
            logic              w_inj_valid;
            logic              w_inj_last;
            logic [SELW_R-1:0] w_sel;
            logic [DATA_W-1:0] w_dl_data;
            logic              w_dl_valid;
            logic              w_dl_last;
            logic [DATA_W-1:0] r_out_data;
            logic              r_out_valid;
            logic              r_out_last;

            // Masked rows and non-fire cycles inject a bubble.
            assign w_row_on    = w_fire & (w_k > RW'(gi));
            assign w_inj_data  = w_row_on ? in_data[gi*DATA_W +: DATA_W] : {DATA_W{1'b0}};
            assign w_inj_valid = w_row_on;
            assign w_inj_last  = w_row_on & in_last;

`ifdef SKEW_FEEDER_DESKEW_EN
            assign w_sel = (w_dsk && (w_k > RW'(gi))) ?
                           SELW_R'(w_k - RW'(1'b1) - RW'(gi)) : SELW_R'(gi);
`else
            assign w_sel = SELW_R'(gi);
`endif

            skew_delay_line #(
                .DEPTH  (D),
                .DATA_W (DATA_W)
            ) u_dl (
                .clk     (clk),
                .reset   (reset),
                .i_en    (array_en),
                .i_clr   (w_clr),
                .i_sel   (w_sel),
                .i_data  (w_inj_data),
                .i_valid (w_inj_valid),
                .i_last  (w_inj_last),
                .o_data  (w_dl_data),
                .o_valid (w_dl_valid),
                .o_last  (w_dl_last)
            );

            // Row output register: the final stage of the row's delay.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_out_data  <= {DATA_W{1'b0}};
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                end else if (array_en) begin
                    r_out_data  <= w_dl_data;
                    r_out_valid <= w_dl_valid;
                    r_out_last  <= w_dl_last;
                end
            end

            assign out_data[gi*DATA_W +: DATA_W] = r_out_data;
            assign out_valid[gi]                 = r_out_valid;
            assign out_last[gi]                  = r_out_last;
        end
    endgenerate

endmodule

// File: tb/tb_skew_feeder.sv
// Self-checking bench for skew_feeder (N=4, DATA_W=8). The reference model
// schedules every accepted column element at "advance count + row delay"
// and predicts ready/busy/tile_done from the tile-level rules.
module tb_skew_feeder;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TM = 4096;

    logic          clk = 1'b0;
    logic          reset;
    logic          array_en;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          in_last;
    logic [2:0]    active_rows;
    logic          deskew;
    logic [31:0]   out_data;
    logic [3:0]    out_valid;
    logic [3:0]    out_last;
    logic          tile_done;
    logic          busy;

    int total = 0;
    int bad   = 0;

    // reference model state
    int        t;
    bit        m_busy;
    bit        m_drain;
    bit        m_dsk;
    int        m_k;
    bit        last_fire;
    logic [7:0] s_d [0:3][0:TM-1];
    bit         s_v [0:3][0:TM-1];
    bit         s_l [0:3][0:TM-1];

    skew_feeder #(.N(N), .DATA_W(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .array_en    (array_en),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .active_rows (active_rows),
`ifdef SKEW_FEEDER_DESKEW_EN
        .deskew      (deskew),
`endif
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .tile_done   (tile_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < TM; k++) begin
                s_d[r][k] = 8'h00;
                s_v[r][k] = 1'b0;
                s_l[r][k] = 1'b0;
            end
        end
        m_busy  = 1'b0;
        m_drain = 1'b0;
        m_dsk   = 1'b0;
        m_k     = N;
    endtask

    function automatic bit exp_done();
        int r;
        r = m_dsk ? 0 : m_k - 1;
        return m_drain && s_l[r][t];
    endfunction

    task automatic check_outs();
        logic [31:0] ed;
        logic [3:0]  ev;
        logic [3:0]  el;
        for (int i = 0; i < 4; i++) begin
            ed[i*8 +: 8] = s_v[i][t] ? s_d[i][t] : 8'h00;
            ev[i]        = s_v[i][t];
            el[i]        = s_l[i][t];
        end
        chk("out_data",  out_data,  ed);
        chk("out_valid", out_valid, ev);
        chk("out_last",  out_last,  el);
        chk("tile_done", tile_done, exp_done());
        chk("busy",      busy,      m_busy);
    endtask

    // one clock: drive at posedge+1, check ready, advance the model, check outputs
    task automatic step(input bit v, input logic [31:0] d, input bit l,
                        input logic [2:0] rows, input bit dsk, input bit en);
        bit rdy;
        bit fire;
        bit dpre;
        int k;
        int dl;
        in_valid    = v;
        in_data     = d;
        in_last     = l;
        active_rows = rows;
        deskew      = dsk;
        array_en    = en;
        #1;
        rdy = en && !m_drain;
        chk("in_ready", in_ready, rdy);
        fire      = v && rdy;
        dpre      = exp_done();
        last_fire = fire;
        @(posedge clk);
        #1;
        if (en) begin
            if (t < TM - 8) t++;
            if (dpre) begin
                m_busy  = 1'b0;
                m_drain = 1'b0;
            end
            if (fire) begin
                if (!m_busy) begin
                    m_busy = 1'b1;
                    k = int'(rows);
                    if (k == 0 || k > N) k = N;
                    m_k = k;
`ifdef SKEW_FEEDER_DESKEW_EN
                    m_dsk = dsk;
`else
                    m_dsk = 1'b0;
`endif
                end
                for (int i = 0; i < m_k; i++) begin
                    dl = m_dsk ? (m_k - 1 - i) : i;
                    s_d[i][t + dl] = d[i*8 +: 8];
                    s_v[i][t + dl] = 1'b1;
                    s_l[i][t + dl] = l;
                end
                if (l) m_drain = 1'b1;
            end
        end
        check_outs();
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, 32'h0, 1'b0, 3'($urandom_range(0, 7)), 1'b0, 1'b1);
    endtask

    function automatic logic [31:0] col(input int c, input logic [7:0] base);
        logic [7:0] b;
        b = base * 8'(c + 1);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    // fire len beats back to back (valid held), waiting on ready as needed
    task automatic send_tile(input int len, input logic [2:0] rows, input bit dsk, input logic [7:0] base);
        int sent;
        int guard;
        sent  = 0;
        guard = 0;
        while (sent < len && guard < 60) begin
            step(1'b1, col(sent, base), sent == len - 1, rows, dsk, 1'b1);
            if (last_fire) sent++;
            guard++;
        end
        chk("send_budget", 32'(sent), 32'(len));
    endtask

    initial begin
        reset       = 1'b1;
        array_en    = 1'b0;
        in_valid    = 1'b0;
        in_data     = 32'h0;
        in_last     = 1'b0;
        active_rows = 3'd0;
        deskew      = 1'b0;
        t           = 0;
        model_reset();
        #3;
        check_outs();
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;

        // 1: full tile, K=4
        send_tile(4, 3'd4, 1'b0, 8'h11);
        idle(6);

        // 2: K=2, 3 columns
        send_tile(3, 3'd2, 1'b0, 8'h21);
        idle(5);

        // 3: freeze mid-STREAM and during DRAIN
        step(1'b1, col(0, 8'h31), 1'b0, 3'd4, 1'b0, 1'b1);
        step(1'b1, col(1, 8'h31), 1'b0, 3'd4, 1'b0, 1'b1);
        for (int j = 0; j < 3; j++) step(1'b1, col(2, 8'h31), 1'b0, 3'd4, 1'b0, 1'b0);
        step(1'b1, col(2, 8'h31), 1'b0, 3'd4, 1'b0, 1'b1);
        step(1'b1, col(3, 8'h31), 1'b1, 3'd4, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 3'd4, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 3'd4, 1'b0, 1'b1);
        for (int j = 0; j < 3; j++) step(1'b0, 32'h0, 1'b0, 3'd4, 1'b0, 1'b0);
        idle(6);

        // 4: single-beat tile (K=1) straight into a K=3 tile; also clamp of 0 and 7
        send_tile(1, 3'd1, 1'b0, 8'h41);
        send_tile(3, 3'd3, 1'b0, 8'h05);
        send_tile(2, 3'd0, 1'b0, 8'h09);
        send_tile(1, 3'd7, 1'b0, 8'h0d);
        idle(6);

        // 5: async reset between edges mid-STREAM
        step(1'b1, col(0, 8'h51), 1'b0, 3'd4, 1'b0, 1'b1);
        step(1'b1, col(1, 8'h51), 1'b0, 3'd4, 1'b0, 1'b1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_outs();
        in_valid = 1'b0;
        array_en = 1'b0;
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        check_outs();
        send_tile(4, 3'd4, 1'b0, 8'h11);
        idle(6);

`ifdef SKEW_FEEDER_DESKEW_EN
        // 6: deskew, K=4 and K=2
        send_tile(4, 3'd4, 1'b1, 8'h61);
        idle(6);
        send_tile(3, 3'd2, 1'b1, 8'h71);
        idle(6);
`endif

        // random tiles with bubbles, freezes and varying active_rows
        for (int tile = 0; tile < 25; tile++) begin
            int  len;
            int  sent;
            int  guard;
            bit  dsk;
            len   = $urandom_range(1, 5);
            sent  = 0;
            guard = 0;
`ifdef SKEW_FEEDER_DESKEW_EN
            dsk = 1'($urandom_range(0, 1));
`else
            dsk = 1'b0;
`endif
            while (sent < len && guard < 200) begin
                step(($urandom % 4) != 0, $urandom, sent == len - 1,
                     3'($urandom_range(0, 7)), dsk, ($urandom % 5) != 0);
                if (last_fire) sent++;
                guard++;
            end
            chk("rand_budget", 32'(sent), 32'(len));
        end
        for (int g = 0; g < 60 && m_busy; g++) begin
            step(1'b0, 32'h0, 1'b0, 3'd0, 1'b0, ($urandom % 4) != 0);
        end
        chk("drain_timeout", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
